// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point DIT FFT/IFFT blocks: width defaults,
// Q1.7 twiddle constants (forward and inverse), bit reversal and FSM states.
package fft_pkg;

    localparam int DW_DEF  = 9;
    localparam int OW_DEF  = 12;
    localparam int TWW_DEF = 9;

    // Forward twiddles W8^k, Q1.7
    localparam int W0_RE  = 128;
    localparam int W0_IM  = 0;
    localparam int W1_RE  = 91;
    localparam int W1_IM  = -91;
    localparam int W2_RE  = 0;
    localparam int W2_IM  = -128;
    localparam int W3_RE  = -91;
    localparam int W3_IM  = -91;

    // Inverse (conjugate) twiddles W8^-k, Q1.7
    localparam int IW0_RE = 128;
    localparam int IW0_IM = 0;
    localparam int IW1_RE = 91;
    localparam int IW1_IM = 91;
    localparam int IW2_RE = 0;
    localparam int IW2_IM = 128;
    localparam int IW3_RE = -91;
    localparam int IW3_IM = 91;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        CALC   = 2'd1,
        UNLOAD = 2'd2
    } state_e;

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 IFFT butterfly: x = a + W*b, y = a - W*b with W = W8^-tw_sel.
// IFFT_STAGE_SCALE_EN defined: both results are arithmetic-shifted right by 1.
module ifft_bfly
    import fft_pkg::*;
#(
    parameter int OW  = OW_DEF,
    parameter int TWW = TWW_DEF
) (
    input  logic signed [OW-1:0] a_re,
    input  logic signed [OW-1:0] a_im,
    input  logic signed [OW-1:0] b_re,
    input  logic signed [OW-1:0] b_im,
    input  logic [1:0]           tw_sel,
    output logic signed [OW-1:0] x_re,
    output logic signed [OW-1:0] x_im,
    output logic signed [OW-1:0] y_re,
    output logic signed [OW-1:0] y_im
);
    localparam int PW  = OW + TWW + 1;
    localparam int FB  = TWW - 2;
    localparam int RND = 1 << (FB - 1);

    logic signed [TWW-1:0] w_re, w_im;
    logic signed [PW-1:0]  p_re, p_im;
    logic signed [OW-1:0]  t_re, t_im;
`ifdef IFFT_STAGE_SCALE_EN
    logic signed [OW:0]    s_re, s_im, d_re, d_im;
`endif

    always_comb begin
        w_re = tw_sel[1] ? TWW'(IW3_RE) : TWW'(IW1_RE);
        w_im = tw_sel[1] ? TWW'(IW3_IM) : TWW'(IW1_IM);
        p_re = PW'(w_re) * PW'(b_re) - PW'(w_im) * PW'(b_im);
        p_im = PW'(w_re) * PW'(b_im) + PW'(w_im) * PW'(b_re);

        // k0 and k2 are exact; only odd twiddles go through the rounded multiply
        case (tw_sel)
            2'd0: begin
                t_re = b_re;
                t_im = b_im;
            end
            2'd2: begin
                t_re = -b_im;
                t_im = b_re;
            end
            default: begin
                t_re = OW'((p_re + PW'(RND)) >>> FB);
                t_im = OW'((p_im + PW'(RND)) >>> FB);
            end
        endcase

`ifdef IFFT_STAGE_SCALE_EN
        s_re = (OW+1)'(a_re) + (OW+1)'(t_re);
        s_im = (OW+1)'(a_im) + (OW+1)'(t_im);
        d_re = (OW+1)'(a_re) - (OW+1)'(t_re);
        d_im = (OW+1)'(a_im) - (OW+1)'(t_im);
        x_re = OW'(s_re >>> 1);
        x_im = OW'(s_im >>> 1);
        y_re = OW'(d_re >>> 1);
        y_im = OW'(d_im >>> 1);
`else
        x_re = a_re + t_re;
        x_im = a_im + t_im;
        y_re = a_re - t_re;
        y_im = a_im - t_im;
`endif
    end

endmodule

// File: rtl/dit_ifft_8_seq.sv
// 8-point radix-2 DIT inverse FFT: loads 8 bins bit-reversed, runs 12 in-place
// butterflies on one shared unit, then streams 8 samples. IFFT_STAGE_SCALE_EN selects 1/8 gain.
module dit_ifft_8_seq
    import fft_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int OW  = OW_DEF,
    parameter int TWW = TWW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_re,
    output logic [OW-1:0] out_im,
    output logic [2:0]    out_idx,
    output logic          busy
);
    state_e               state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic [2:0]           n_q, n_d;
    logic [1:0]           stage_q, stage_d;
    logic [1:0]           bf_q, bf_d;
    logic signed [OW-1:0] buf_re_q [8];
    logic signed [OW-1:0] buf_im_q [8];
    logic signed [OW-1:0] buf_re_d [8];
    logic signed [OW-1:0] buf_im_d [8];

    logic [2:0]           top_idx, bot_idx;
    logic [1:0]           tw_sel;
    logic signed [OW-1:0] x_re, x_im, y_re, y_im;

    // Stage s pairs entries 2^s apart; twiddle index is (j mod 2^s) * 2^(2-s)
    always_comb begin
        top_idx = {bf_q, 1'b0};
        bot_idx = {bf_q, 1'b1};
        tw_sel  = '0;
        case (stage_q)
            2'd1: begin
                top_idx = {bf_q[1], 1'b0, bf_q[0]};
                bot_idx = {bf_q[1], 1'b1, bf_q[0]};
                tw_sel  = {bf_q[0], 1'b0};
            end
            2'd2: begin
                top_idx = {1'b0, bf_q};
                bot_idx = {1'b1, bf_q};
                tw_sel  = bf_q;
            end
            default: ;
        endcase
    end

    ifft_bfly #(
        .OW  (OW),
        .TWW (TWW)
    ) u_bfly (
        .a_re   (buf_re_q[top_idx]),
        .a_im   (buf_im_q[top_idx]),
        .b_re   (buf_re_q[bot_idx]),
        .b_im   (buf_im_q[bot_idx]),
        .tw_sel (tw_sel),
        .x_re   (x_re),
        .x_im   (x_im),
        .y_re   (y_re),
        .y_im   (y_im)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        stage_d   = stage_q;
        bf_d      = bf_q;
        buf_re_d  = buf_re_q;
        buf_im_d  = buf_im_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_re    = '0;
        out_im    = '0;
        out_idx   = n_q;

        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_re_d[bitrev3(k_q)] = {{(OW-DW){in_re[DW-1]}}, in_re};
                    buf_im_d[bitrev3(k_q)] = {{(OW-DW){in_im[DW-1]}}, in_im};
                    k_d = k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        state_d = CALC;
                        stage_d = '0;
                        bf_d    = '0;
                    end
                end
            end
            CALC: begin
                busy              = 1'b1;
                buf_re_d[top_idx] = x_re;
                buf_im_d[top_idx] = x_im;
                buf_re_d[bot_idx] = y_re;
                buf_im_d[bot_idx] = y_im;
                bf_d              = bf_q + 2'd1;
                if (bf_q == 2'd3) begin
                    stage_d = stage_q + 2'd1;
                    if (stage_q == 2'd2) begin
                        state_d = UNLOAD;
                        stage_d = '0;
                        n_d     = '0;
                    end
                end
            end
            UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_re    = buf_re_q[n_q];
                out_im    = buf_im_q[n_q];
                if (out_ready) begin
                    n_d = n_q + 3'd1;
                    if (n_q == 3'd7) begin
                        state_d = LOAD;
                        k_d     = '0;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            k_q     <= '0;
            n_q     <= '0;
            stage_q <= '0;
            bf_q    <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                buf_re_q[i] <= '0;
                buf_im_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_q      <= n_d;
            stage_q  <= stage_d;
            bf_q     <= bf_d;
            buf_re_q <= buf_re_d;
            buf_im_q <= buf_im_d;
        end
    end

endmodule
